// File: rtl/ins_mem_loader_if.sv
// Byte-stream load port and instruction-memory write port of the loader.
// The master side is the host/stream source; the slave side is the loader itself.
interface ins_mem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic [ADDR_WIDTH:0]   loadLen;
   logic                  abort;
   logic [7:0]            inByte;
   logic                  inValid;
   logic                  inReady;
   logic                  wrEn;
   logic [ADDR_WIDTH-1:0] wrAddr;
   logic [31:0]           wrData;
   logic                  busy;
   logic                  done;
   logic                  cpuHold;

   modport master (
      output start, loadLen, abort, inByte, inValid,
      input  inReady, wrEn, wrAddr, wrData, busy, done, cpuHold
   );

   modport slave (
      input  start, loadLen, abort, inByte, inValid,
      output inReady, wrEn, wrAddr, wrData, busy, done, cpuHold
   );
endinterface

// File: rtl/ins_mem_loader.sv
// Packs a byte stream MSB-first into 32-bit words and writes them to instruction memory.
// One word every 5 cycles at best (4 bytes + 1 write); inReady drops outside ASSEMBLE to stall the source.
module ins_mem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   ins_mem_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} state_t;

   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

   state_t                state;
   state_t                nextState;
   logic [ADDR_WIDTH:0]   effLen;
   logic [ADDR_WIDTH:0]   startLen;
   logic [ADDR_WIDTH-1:0] index;
   logic [1:0]            byteCnt;
   logic [23:0]           partial;
   logic                  startAcc;
   logic                  byteAcc;
   logic                  lastWord;

   // Lengths beyond the memory are clamped so the index can never wrap.
   assign startLen = (bus.loadLen > MAX_LEN) ? MAX_LEN : bus.loadLen;
   assign startAcc = ((state == IDLE) || (state == DONE)) && bus.start && !bus.abort;
   assign byteAcc  = (state == ASSEMBLE) && bus.inValid && !bus.abort;
   assign lastWord = ({1'b0, index} == (effLen - LEN_ONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: begin
            if (startAcc) begin
               nextState = (startLen == '0) ? DONE : ASSEMBLE;
            end
         end
         ASSEMBLE: begin
            if (bus.abort) begin
               nextState = IDLE;
            end else if (byteAcc && (byteCnt == 2'd3)) begin
               nextState = WRITE;
            end
         end
         WRITE: begin
            if (bus.abort) begin
               nextState = IDLE;
            end else if (lastWord) begin
               nextState = DONE;
            end else begin
               nextState = ASSEMBLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.inReady = (state == ASSEMBLE);
      bus.wrEn    = (state == WRITE) && !bus.abort;
      bus.busy    = (state == ASSEMBLE) || (state == WRITE);
      bus.done    = (state == DONE);
      bus.cpuHold = (state != DONE);
   end

   // wrAddr/wrData are loaded as the word completes so they are valid throughout WRITE and hold afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         effLen     <= '0;
         index      <= '0;
         byteCnt    <= '0;
         partial    <= '0;
         bus.wrAddr <= '0;
         bus.wrData <= '0;
      end else begin
         if (startAcc) begin
            effLen  <= startLen;
            index   <= '0;
            byteCnt <= '0;
         end
         if (bus.abort && ((state == ASSEMBLE) || (state == WRITE))) begin
            byteCnt <= '0;
         end
         if (byteAcc) begin
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
               bus.wrData <= {partial, bus.inByte};
               bus.wrAddr <= index;
            end else begin
               partial <= {partial[15:0], bus.inByte};
            end
         end
         if ((state == WRITE) && !bus.abort && !lastWord) begin
            index <= index + IDX_ONE;
         end
      end
   end
endmodule

// File: tb/tb_ins_mem_loader.sv
// Randomized scoreboard bench for ins_mem_loader: stimulus pushes expected writes, a negedge monitor checks them.
module tb_ins_mem_loader;
   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ins_mem_loader_if #(.ADDR_WIDTH(AW)) bus();
   ins_mem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   wr_t expQ[$];
   int  wrCyc[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  startCyc = 0;
   int  bytesSeen = 0;
   int  lastFourth = -100;
   bit  chkTiming = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: tracks accepted bytes and checks every write strobe against the scoreboard.
   always @(negedge clk) begin
      if (rst || bus.abort || (bus.start && !bus.busy)) begin
         bytesSeen = 0;
      end else if (bus.inValid && bus.inReady) begin
         bytesSeen++;
         if (bytesSeen % 4 == 0) lastFourth = cyc;
      end
      if (bus.wrEn) begin
         wrCyc.push_back(cyc);
         if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_write: addr %0h data %0h, expected no write", bus.wrAddr, bus.wrData);
         end else begin
            wr_t e;
            e = expQ.pop_front();
            chk("wr_addr", 64'(bus.wrAddr), 64'(e.addr));
            chk("wr_data", 64'(bus.wrData), 64'(e.data));
            if (chkTiming) chk("wr_after_4th_byte", 64'(cyc - lastFourth), 64'd1);
         end
      end
   end

   // Reference: word w is bytes 4w..4w+3 MSB-first at address w, for w below min(len, DEPTH).
   function automatic void expectLoad(input bq_t b, input int len);
      int eff;
      eff = (len > DEPTH) ? DEPTH : len;
      for (int w = 0; w < eff; w++) begin
         wr_t e;
         e.addr = AW'(w);
         e.data = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
         expQ.push_back(e);
      end
   endfunction

   function automatic bq_t randBytes(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      return q;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doStart(input int len);
      bus.loadLen = (AW+1)'(len);
      bus.start   = 1'b1;
      startCyc    = cyc;
      tick();
      bus.start   = 1'b0;
   endtask

   task automatic feed(input bq_t b, input bit stall);
      int i = 0;
      int n = 0;
      while (i < b.size() && n < 20000) begin
         bus.inByte  = b[i];
         bus.inValid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (bus.inValid && bus.inReady) i++;
         tick();
         n++;
      end
      bus.inValid = 1'b0;
      if (i < b.size()) chk("feed_timeout", 64'(i), 64'(b.size()));
   endtask

   task automatic waitDone(input string name, input int budget);
      int n = 0;
      while (!bus.done && n < budget) begin
         tick();
         n++;
      end
      chk(name, 64'(bus.done), 64'd1);
   endtask

   task automatic checkReset(input string tag);
      chk({tag, "_inReady"}, 64'(bus.inReady), 64'd0);
      chk({tag, "_wrEn"},    64'(bus.wrEn),    64'd0);
      chk({tag, "_wrAddr"},  64'(bus.wrAddr),  64'd0);
      chk({tag, "_wrData"},  64'(bus.wrData),  64'd0);
      chk({tag, "_busy"},    64'(bus.busy),    64'd0);
      chk({tag, "_done"},    64'(bus.done),    64'd0);
      chk({tag, "_cpuHold"}, 64'(bus.cpuHold), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t prog;
      bq_t r;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.loadLen = '0;
      bus.abort   = 1'b0;
      bus.inByte  = '0;
      bus.inValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkReset("reset");
      rst = 1'b0;
      tick();

      // Basic two-word load with the stream held valid.
      prog = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
      wrCyc.delete();
      expectLoad(prog, 2);
      doStart(2);
      feed(prog, 1'b0);
      waitDone("basic_done", 20);
      chk("basic_nwrites", 64'(wrCyc.size()), 64'd2);
      if (wrCyc.size() == 2) begin
         chk("basic_wr0_cycle", 64'(wrCyc[0] - startCyc), 64'd5);
         chk("basic_wr1_cycle", 64'(wrCyc[1] - startCyc), 64'd10);
      end
      chk("basic_cpuHold", 64'(bus.cpuHold), 64'd0);
      chk("basic_queue", 64'(expQ.size()), 64'd0);

      // Same stream with a randomly stalling source.
      wrCyc.delete();
      chkTiming = 1'b1;
      expectLoad(prog, 2);
      doStart(2);
      feed(prog, 1'b1);
      waitDone("stall_done", 20);
      chk("stall_nwrites", 64'(wrCyc.size()), 64'd2);
      chk("stall_queue", 64'(expQ.size()), 64'd0);

      // Abort two bytes into word 1: only word 0 lands.
      r = randBytes(8);
      expectLoad(r, 1);
      doStart(2);
      feed(r[0:5], 1'b0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_cpuHold", 64'(bus.cpuHold), 64'd1);
      chk("abort_done", 64'(bus.done), 64'd0);
      bus.inValid = 1'b1;
      bus.inByte  = 8'hA5;
      repeat (3) tick();
      chk("idle_inReady", 64'(bus.inReady), 64'd0);
      chk("idle_busy", 64'(bus.busy), 64'd0);
      bus.inValid = 1'b0;
      chk("abort_queue", 64'(expQ.size()), 64'd0);
      r = randBytes(4);
      expectLoad(r, 1);
      doStart(1);
      feed(r, 1'b1);
      waitDone("after_abort_done", 20);
      chk("after_abort_queue", 64'(expQ.size()), 64'd0);

      // Reload from DONE.
      r = randBytes(4);
      expectLoad(r, 1);
      doStart(1);
      chk("reload_done", 64'(bus.done), 64'd0);
      chk("reload_cpuHold", 64'(bus.cpuHold), 64'd1);
      chk("reload_busy", 64'(bus.busy), 64'd1);
      feed(r, 1'b0);
      waitDone("reload_done_again", 20);
      chk("reload_cpuHold_low", 64'(bus.cpuHold), 64'd0);
      chk("reload_queue", 64'(expQ.size()), 64'd0);

      // Asynchronous reset landing mid-WRITE: no write may complete.
      r = randBytes(4);
      doStart(1);
      feed(r, 1'b0);
      chk("pre_rst_wrEn", 64'(bus.wrEn), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkReset("arst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
      chk("post_rst_done", 64'(bus.done), 64'd0);
      chk("post_rst_cpuHold", 64'(bus.cpuHold), 64'd1);

      // Zero length goes straight to DONE.
      wrCyc.delete();
      doStart(0);
      chk("len0_done", 64'(bus.done), 64'd1);
      chk("len0_busy", 64'(bus.busy), 64'd0);
      chk("len0_cpuHold", 64'(bus.cpuHold), 64'd0);
      tick();
      chk("len0_nwrites", 64'(wrCyc.size()), 64'd0);

      // Oversize length is clamped to the full memory.
      wrCyc.delete();
      r = randBytes(4 * DEPTH);
      expectLoad(r, 300);
      doStart(300);
      feed(r, 1'b0);
      waitDone("len300_done", 20);
      chk("len300_nwrites", 64'(wrCyc.size()), 64'(DEPTH));
      chk("len300_last_addr", 64'(bus.wrAddr), 64'(DEPTH - 1));
      chk("len300_queue", 64'(expQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
